// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and CDB packet types for the completion-data-bus arbiter.
// Other blocks import this package to see one CDB slot as a single struct.
package cdb_arbiter_pkg;

  localparam int ROB_IDX_LEN       = 5;
  localparam int XLEN              = 32;
  localparam int NUM_FU_DEFAULT    = 4;
  localparam int CDB_WIDTH_DEFAULT = 2;

  typedef struct packed {
    logic                   valid;
    logic [ROB_IDX_LEN-1:0] rob_idx;
    logic [XLEN-1:0]        value;
    logic                   mis_pred;
  } cdb_entry_t;

  typedef cdb_entry_t [CDB_WIDTH_DEFAULT-1:0] cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_sel.sv
// One-hot first-set picker: scans req circularly starting at base and
// returns the first requester found (grant, its index, and a found flag).
module rr_priority_sel #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] base,
  output logic [N-1:0]     grant,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  int               pos_int;
  logic [PTR_W-1:0] pos;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx     = '0;
    pos_int = 0;
    pos     = '0;
    for (int off = 0; off < N; off++) begin
      pos_int = (int'(base) + off) % N;
      pos     = PTR_W'(pos_int);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing up to CDB_WIDTH completing FUs per cycle onto a
// registered CDB; losers are held off through fu_ready.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = NUM_FU_DEFAULT,
  parameter int CDB_WIDTH = CDB_WIDTH_DEFAULT
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU*ROB_IDX_LEN-1:0]    fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]           fu_value,
  input  logic [NUM_FU-1:0]                fu_mis_pred,
  output logic [NUM_FU-1:0]                fu_ready,
  output logic [CDB_WIDTH-1:0]             cdb_valid,
  output logic [CDB_WIDTH*ROB_IDX_LEN-1:0] cdb_rob_idx,
  output logic [CDB_WIDTH*XLEN-1:0]        cdb_value,
  output logic [CDB_WIDTH-1:0]             cdb_mis_pred,
  output logic [$clog2(NUM_FU)-1:0]        rr_ptr
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] req_mask [CDB_WIDTH+1];
  logic [NUM_FU-1:0] grant    [CDB_WIDTH];
  logic [PTR_W-1:0]  sel_idx  [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] found;
  logic [NUM_FU-1:0] grant_any;
  logic [PTR_W-1:0]  rr_next;
  cdb_entry_t        slot_d [CDB_WIDTH];
  cdb_entry_t        slot_q [CDB_WIDTH];

  // Squash blanks every request, so nothing is granted and rr_ptr holds.
  assign req_mask[0] = squash ? '0 : fu_valid;

  // Each slot's picker sees the requests left over after earlier slots took theirs.
  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_slot
    rr_priority_sel #(
      .N     (NUM_FU),
      .PTR_W (PTR_W)
    ) u_sel (
      .req   (req_mask[k]),
      .base  (rr_ptr),
      .grant (grant[k]),
      .found (found[k]),
      .idx   (sel_idx[k])
    );
    assign req_mask[k+1] = req_mask[k] & ~grant[k];
  end

  always_comb begin
    grant_any = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      grant_any = grant_any | grant[k];
    end
  end

  assign fu_ready = reset ? grant_any : '0;

  always_comb begin
    rr_next = rr_ptr;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      slot_d[k] = '0;
      if (found[k]) begin
        slot_d[k].valid    = 1'b1;
        slot_d[k].rob_idx  = fu_rob_idx[int'(sel_idx[k])*ROB_IDX_LEN +: ROB_IDX_LEN];
        slot_d[k].value    = fu_value[int'(sel_idx[k])*XLEN +: XLEN];
        slot_d[k].mis_pred = fu_mis_pred[sel_idx[k]];
        // Slots fill in rr order, so the last found slot holds the last grant.
        rr_next = (sel_idx[k] == PTR_W'(NUM_FU-1)) ? '0 : sel_idx[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    cdb_valid    = '0;
    cdb_rob_idx  = '0;
    cdb_value    = '0;
    cdb_mis_pred = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb_valid[k]                              = slot_q[k].valid;
      cdb_rob_idx[k*ROB_IDX_LEN +: ROB_IDX_LEN] = slot_q[k].rob_idx;
      cdb_value[k*XLEN +: XLEN]                 = slot_q[k].value;
      cdb_mis_pred[k]                           = slot_q[k].mis_pred;
    end
  end

`ifndef SYNTHESIS
  logic dup_idx;

  always_comb begin
    dup_idx = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int j = i + 1; j < NUM_FU; j++) begin
        if (fu_valid[i] && fu_valid[j] &&
            fu_rob_idx[i*ROB_IDX_LEN +: ROB_IDX_LEN] == fu_rob_idx[j*ROB_IDX_LEN +: ROB_IDX_LEN]) begin
          dup_idx = 1'b1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      assert (!dup_idx) else $error("two valid FUs share one rob_idx");
    end
  end
`endif

endmodule
